// File: rtl/fm0_fifo_tx.sv
// Gen2 FM0 backscatter transmitter fed from the read side of an 8-bit FIFO.
// Sends the preamble, N prefetched bytes MSB-first, then the dummy-1 symbol.
module fm0_fifo_tx #(
    parameter int HALF_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_count,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx_out,
    output logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DUMMY} state_t;

    localparam int             HBW             = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [HBW-1:0] HB_MAX          = HBW'(HALF_BIT - 1);
    localparam logic [11:0]    PREAMBLE_LEVELS = 12'b1101_0010_0011;

    state_t         state;
    logic [HBW-1:0] hb_cnt;
    logic [3:0]     pre_idx;
    logic           half;
    logic [2:0]     bit_idx;
    logic [7:0]     tx_left;
    logic [7:0]     fetch_left;
    logic [7:0]     shift_reg;
    logic [7:0]     hold_reg;
    logic           read_d;

    logic           hb_last;
    logic           read_due;
    logic           starve;
    logic [7:0]     next_byte;

    // A prefetch is due on the first cycle of the last preamble symbol and on the
    // first cycle of each byte's LSB; an empty FIFO at that moment is an underrun.
    // The byte popped one cycle earlier may still be on fifo_data, so it bypasses
    // the holding register when a byte boundary follows immediately.
    always_comb begin
        hb_last  = (hb_cnt == HB_MAX);
        read_due = 1'b0;
        if (hb_cnt == '0 && fetch_left != 8'd0) begin
            if ((state == PREAMBLE && pre_idx == 4'd10) ||
                (state == DATA && bit_idx == 3'd0 && !half)) begin
                read_due = 1'b1;
            end
        end
        fifo_read = read_due && !fifo_empty;
        starve    = read_due && fifo_empty;
        next_byte = read_d ? fifo_data : hold_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hb_cnt     <= '0;
            pre_idx    <= 4'd0;
            half       <= 1'b0;
            bit_idx    <= 3'd0;
            tx_left    <= 8'd0;
            fetch_left <= 8'd0;
            shift_reg  <= 8'd0;
            hold_reg   <= 8'd0;
            read_d     <= 1'b0;
            tx_out     <= 1'b0;
            tx_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done   <= 1'b0;
            read_d <= fifo_read;
            if (read_d) begin
                hold_reg <= fifo_data;
            end
            if (fifo_read) begin
                fetch_left <= fetch_left - 8'd1;
            end

            if (state == IDLE) begin
                if (start) begin
                    state      <= PREAMBLE;
                    hb_cnt     <= '0;
                    pre_idx    <= 4'd0;
                    half       <= 1'b0;
                    tx_left    <= byte_count;
                    fetch_left <= byte_count;
                    tx_out     <= PREAMBLE_LEVELS[11];
                    tx_en      <= 1'b1;
                    busy       <= 1'b1;
                    underrun   <= 1'b0;
                end
            end else if (starve) begin
                state    <= IDLE;
                hb_cnt   <= '0;
                tx_out   <= 1'b0;
                tx_en    <= 1'b0;
                busy     <= 1'b0;
                underrun <= 1'b1;
            end else if (!hb_last) begin
                hb_cnt <= hb_cnt + HBW'(1);
            end else begin
                hb_cnt <= '0;
                case (state)
                    PREAMBLE: begin
                        if (pre_idx != 4'd11) begin
                            pre_idx <= pre_idx + 4'd1;
                            tx_out  <= PREAMBLE_LEVELS[4'd10 - pre_idx];
                        end else begin
                            half   <= 1'b0;
                            tx_out <= ~tx_out;
                            if (tx_left == 8'd0) begin
                                state <= DUMMY;
                            end else begin
                                state     <= DATA;
                                shift_reg <= next_byte;
                                bit_idx   <= 3'd7;
                            end
                        end
                    end
                    DATA: begin
                        if (!half) begin
                            half <= 1'b1;
                            if (!shift_reg[bit_idx]) begin
                                tx_out <= ~tx_out;
                            end
                        end else begin
                            half   <= 1'b0;
                            tx_out <= ~tx_out;
                            if (bit_idx != 3'd0) begin
                                bit_idx <= bit_idx - 3'd1;
                            end else begin
                                tx_left <= tx_left - 8'd1;
                                if (tx_left == 8'd1) begin
                                    state <= DUMMY;
                                end else begin
                                    shift_reg <= next_byte;
                                    bit_idx   <= 3'd7;
                                end
                            end
                        end
                    end
                    DUMMY: begin
                        if (!half) begin
                            half <= 1'b1;
                        end else begin
                            half   <= 1'b0;
                            state  <= IDLE;
                            tx_out <= 1'b0;
                            tx_en  <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/fm0_fifo_tx.md
# fm0_fifo_tx

Byte-to-backscatter transmit stage that sits directly downstream of the 8-bit `FIFO`, on its read side. On a `start` pulse it emits the Gen2 FM0 preamble, pops `byte_count` bytes from the FIFO, and serialises them MSB-first as FM0 symbols. It then appends the dummy-1 end-of-signalling symbol and drives the tag modulator enable/level.

## Interface
- `HALF_BIT`, default 4: clock cycles per FM0 half-bit; must be ≥ 1. One FM0 bit lasts 2·HALF_BIT cycles.
- `clk`  input  1  single clock; the FIFO's read clock (`r_clk` domain).
- `reset`  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start`  input  1  one-cycle request to begin a frame; ignored while `busy`=1.
- `byte_count`  input  8  number of bytes to send; sampled on the accepted `start`. 0 is legal.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_data`  input  8  FIFO `data_out`; valid the cycle after `fifo_read`.
- `fifo_read`  output  1  one-cycle pop strobe to the FIFO `read` input.
- `tx_out`  output  1  FM0 modulator level.
- `tx_en`  output  1  high while a frame is on air.
- `busy`  output  1  high from the accepted `start` until the frame ends or aborts.
- `done`  output  1  one-cycle pulse on successful frame completion.
- `underrun`  output  1  sticky abort flag; cleared by the next accepted `start` or by `reset`.

## Operation
- States:
  - IDLE
  - PREAMBLE: 6 symbols.
  - DATA: 8·N bits.
  - DUMMY: 1 symbol.
  - IDLE.
- A half-bit counter (0..HALF_BIT-1), a half index, a bit index (0..7), a remaining-byte counter, a shift register and a 1-byte holding register drive the datapath.
- FM0 rule for data and dummy bits: `tx_out` inverts at every bit boundary. Data-0 also inverts at mid-bit; data-1 does not.
- Preamble (1 0 1 0 v 1) is a fixed 12-half-bit level sequence: 1,1,0,1,0,0,1,0,0,0,1,1. The preamble therefore ends at level 1.
- Prefetch:
  - First byte: `fifo_read` is pulsed on the first cycle of the last preamble symbol.
  - Each next byte: `fifo_read` is pulsed on the first cycle of bit 0 (the LSB) of the current byte, while bytes remain.
  - `fifo_data` is captured into the holding register the following cycle.
  - The holding register loads the shift register at the next byte boundary, so there is no gap between bytes.
- After the last data bit, or after the preamble when N=0, one dummy data-1 symbol is sent. Then `tx_out`=0, `tx_en`=0 and the block returns to IDLE.
- Underrun occurs if `fifo_empty`=1 on a cycle where a prefetch read is due. In that case:
  - No `fifo_read` is issued.
  - The frame aborts immediately: `tx_out`=0, `tx_en`=0, `busy`=0, `underrun`=1.
  - No `done` pulse is produced; the state returns to IDLE.
- `start` while `busy` is ignored. A simultaneous `start` and `reset` resolves to reset.

## Timing
- Reset values: state IDLE; `tx_out`=0, `tx_en`=0, `busy`=0, `done`=0, `fifo_read`=0, `underrun`=0; all counters 0.
- `start` is accepted in cycle T. In T+1 the first preamble half-bit is on `tx_out`, with `tx_en`=1 and `busy`=1.
- Frame length is (7 + 8·N)·2·HALF_BIT cycles, from T+1 through the last dummy half-bit.
- `done`=1 for exactly one cycle, the cycle after the last dummy half-bit. In that same cycle `tx_en`=0, `tx_out`=0 and `busy`=0.
- A new `start` is accepted in the `done` cycle.
- `fifo_read` is never asserted while `fifo_empty`=1 and never more than N times per frame.
- `reset` mid-frame takes effect at the next edge: all outputs return to reset values and no `done` is produced.

## Test plan
- HALF_BIT=1, N=1, FIFO holds 0xA5, `start` at T:
  - `tx_out` from T+1 is 110100100011 (preamble) 0010110101001011 (data) 00 (dummy).
  - `tx_en`=1 for 30 cycles; `done` at T+31; exactly 1 `fifo_read`.
- HALF_BIT=4, N=3, FIFO holds 0x00,0xFF,0x3C:
  - 248-cycle frame, each half-bit held 4 cycles, no gap at byte boundaries.
  - 3 `fifo_read` pulses, each on the first cycle of the preceding LSB (first one on the first cycle of the last preamble symbol).
- N=0:
  - Preamble then dummy (00), 14·HALF_BIT cycles, 0 `fifo_read`, `done` pulses.
- N=4 with only 2 bytes in the FIFO:
  - Abort on the first cycle of byte 2's LSB: `tx_en`→0, `underrun`=1, no `done`.
  - The next `start` clears `underrun`.
- `start` pulsed mid-frame:
  - Ignored; frame length unchanged.
- `reset` mid-DATA:
  - All outputs at reset values next cycle, no `done`.
  - A new frame afterwards transmits correctly from the preamble.
